// File: rtl/w_ram_from_uart_if.sv
// ---------------------------------------------------------------------------
// w_ram_from_uart_if
// Bundles the UART-side inputs and the RAM write-port outputs of the
// UART-to-RAM loader so the block and its users share one port list.
//   uart_rxd    : raw UART RX line (idle high, 8N1, LSB first)
//   ur_wr_start : level enable; low aborts and clears the loader
//   address     : RAM write address (equals the byte counter)
//   wr_data     : RAM write data
//   wr_en       : one-cycle RAM write strobe
//   frame_err   : one-cycle pulse on a bad stop bit
//   ur_wr_end   : held high once the full frame has been written
// Modports: master drives the UART/enable side, slave is the loader itself.
// ---------------------------------------------------------------------------
interface w_ram_from_uart_if #(
    parameter int ADDR_W = 15
);
    logic              uart_rxd;
    logic              ur_wr_start;
    logic [ADDR_W-1:0] address;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              frame_err;
    logic              ur_wr_end;

    modport master (
        output uart_rxd,
        output ur_wr_start,
        input  address,
        input  wr_data,
        input  wr_en,
        input  frame_err,
        input  ur_wr_end
    );

    modport slave (
        input  uart_rxd,
        input  ur_wr_start,
        output address,
        output wr_data,
        output wr_en,
        output frame_err,
        output ur_wr_end
    );
endinterface

// File: rtl/w_ram_from_uart.sv
// ---------------------------------------------------------------------------
// w_ram_from_uart
// Receives a fixed-length byte stream on a UART RX line and writes each byte
// into RAM at consecutive addresses starting from 0. After FULL_NUMBER bytes
// the loader parks in DONE with ur_wr_end held high until ur_wr_start drops.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : w_ram_from_uart_if.slave (UART input, enable, RAM write port)
// ---------------------------------------------------------------------------
module w_ram_from_uart #(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int FULL_NUMBER = 2704,
    parameter int ADDR_W      = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    w_ram_from_uart_if.slave        bus
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB + 1);
    // One extra counter bit so the counter can hold FULL_NUMBER even when it
    // equals 2**ADDR_W.
    localparam int CW   = ADDR_W + 1;

    localparam logic [TW-1:0] HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CPB - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FULL_NUMBER - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WRITE,
        DONE
    } state_t;

    state_t          state_q,     state_d;
    logic            sync1_q,     sync1_d;
    logic            rx_s_q,      rx_s_d;
    logic            rx_prev_q,   rx_prev_d;
    logic [TW-1:0]   timer_q,     timer_d;
    logic [2:0]      bit_idx_q,   bit_idx_d;
    logic [7:0]      shift_q,     shift_d;
    logic [CW-1:0]   count_q,     count_d;
    logic [7:0]      wr_data_q,   wr_data_d;
    logic            wr_en_q,     wr_en_d;
    logic            frame_err_q, frame_err_d;
    logic            ur_wr_end_q, ur_wr_end_d;

    always_comb begin
        state_d     = state_q;
        // Two-flop synchronizer plus one history flop for edge detection.
        // These run every cycle so a start edge is only ever seen as a fresh
        // 1->0 transition of the synchronized line.
        sync1_d     = bus.uart_rxd;
        rx_s_d      = sync1_q;
        rx_prev_d   = rx_s_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        count_d     = count_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
        ur_wr_end_d = ur_wr_end_q;

        if (!bus.ur_wr_start) begin
            // Disable overrides everything: drop any byte in flight and
            // rewind the counter so the next enable starts a fresh frame.
            state_d     = IDLE;
            timer_d     = '0;
            count_d     = '0;
            ur_wr_end_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!ur_wr_end_q && rx_prev_q && !rx_s_q) begin
                        timer_d = '0;
                        state_d = START;
                    end
                end

                START: begin
                    // Re-check the line in the middle of the start bit to
                    // reject short glitches.
                    if (timer_q == HALF_LAST) begin
                        timer_d = '0;
                        if (!rx_s_q) begin
                            bit_idx_d = 3'd0;
                            state_d   = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end

                DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_d            = '0;
                        shift_d[bit_idx_q] = rx_s_q;
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end

                STOP: begin
                    if (timer_q == BIT_LAST) begin
                        timer_d = '0;
                        if (rx_s_q) begin
                            // Strobe and data are registered here so they
                            // are presented together during WRITE.
                            wr_en_d   = 1'b1;
                            wr_data_d = shift_q;
                            state_d   = WRITE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = IDLE;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end

                WRITE: begin
                    // address still shows the pre-increment count this cycle.
                    count_d = count_q + CW'(1);
                    if (count_q == CNT_LAST) begin
                        ur_wr_end_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end

                DONE: begin
                    // Parked until ur_wr_start drops; RX activity ignored.
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            count_q     <= '0;
            wr_data_q   <= 8'h00;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            ur_wr_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
            ur_wr_end_q <= ur_wr_end_d;
        end
    end

    assign bus.address   = count_q[ADDR_W-1:0];
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.frame_err = frame_err_q;
    assign bus.ur_wr_end = ur_wr_end_q;

endmodule

// File: tb/tb_w_ram_from_uart.sv
// ---------------------------------------------------------------------------
// tb_w_ram_from_uart
// Directed bench for w_ram_from_uart with CPB=16 and a 4-byte frame.
// Frames are driven one bit per 16 clocks starting at a falling clock edge;
// outputs are sampled on the falling edge before the next input change.
// Counting that edge as n=0 (start bit driven), a valid byte's write strobe
// appears at n=155 (2 sync + 1 edge + 8 half-bit + 9*16 bit clocks) and the
// done flag at n=156.
// ---------------------------------------------------------------------------
module tb_w_ram_from_uart;
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int FULL     = 4;
    localparam int AW       = 15;
    localparam int WR_AT    = 155;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    w_ram_from_uart_if #(.ADDR_W(AW)) bus ();

    w_ram_from_uart #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .FULL_NUMBER (FULL),
        .ADDR_W      (AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Observations collected while a frame or idle window is driven.
    int          f_wr, f_wr_at, f_fe, f_fe_at, f_end_at, f_both;
    logic [7:0]  f_data;
    logic [AW-1:0] f_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        f_wr = 0; f_wr_at = -1; f_fe = 0; f_fe_at = -1;
        f_end_at = -1; f_both = 0; f_data = 8'h00; f_addr = '0;
    endtask

    task automatic sample(input int n);
        if (bus.wr_en === 1'b1) begin
            f_wr++;
            if (f_wr_at < 0) f_wr_at = n;
            f_data = bus.wr_data;
            f_addr = bus.address;
        end
        if (bus.frame_err === 1'b1) begin
            f_fe++;
            if (f_fe_at < 0) f_fe_at = n;
        end
        if (bus.ur_wr_end === 1'b1 && f_end_at < 0) f_end_at = n;
        if (bus.wr_en === 1'b1 && bus.frame_err === 1'b1) f_both++;
    endtask

    // Drives start bit, 8 data bits, stop bit, then one idle bit time.
    // abort_n / rst_n (>=0) drop ur_wr_start or pulse reset at that slot.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int abort_n, input int rst_n);
        int slot;
        clear_obs();
        for (int n = 0; n < 176; n++) begin
            @(negedge clk);
            sample(n);
            if (n == abort_n) bus.ur_wr_start = 1'b0;
            if (rst_n >= 0 && n == rst_n)     reset = 1'b1;
            if (rst_n >= 0 && n == rst_n + 2) reset = 1'b0;
            slot = n / 16;
            if (slot == 0)      bus.uart_rxd = 1'b0;
            else if (slot <= 8) bus.uart_rxd = b[slot-1];
            else if (slot == 9) bus.uart_rxd = stop_bit;
            else                bus.uart_rxd = 1'b1;
        end
    endtask

    task automatic idle_watch(input int ncyc, input int low_cyc);
        clear_obs();
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            sample(n);
            bus.uart_rxd = (n < low_cyc) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic good_frame(input string tag, input logic [7:0] b, input int exp_addr);
        send_frame(b, 1'b1, -1, -1);
        chk({tag, "_wr_cnt"},  f_wr,    1);
        chk({tag, "_wr_at"},   f_wr_at, WR_AT);
        chk({tag, "_data"},    f_data,  {24'h0, b});
        chk({tag, "_addr"},    f_addr,  exp_addr);
        chk({tag, "_no_ferr"}, f_fe,    0);
    endtask

    logic [7:0] pat1 [4];
    logic [7:0] pat2 [4];

    initial begin
        pat1 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        pat2 = '{8'hC3, 8'h5A, 8'h01, 8'h80};
        bus.uart_rxd    = 1'b1;
        bus.ur_wr_start = 1'b0;
        reset           = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_address",   bus.address,   0);
        chk("rst_wr_data",   bus.wr_data,   0);
        chk("rst_wr_en",     bus.wr_en,     0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_wr_end",    bus.ur_wr_end, 0);
        reset = 1'b0;
        idle_watch(200, 0);
        chk("idle_no_wr", f_wr, 0);

        // Full 4-byte frame
        bus.ur_wr_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            good_frame($sformatf("frame1_b%0d", i), pat1[i], i);
            chk($sformatf("frame1_b%0d_end_at", i), f_end_at, (i == 3) ? WR_AT + 1 : -1);
            chk($sformatf("frame1_b%0d_both", i), f_both, 0);
        end
        chk("done_address", bus.address,   FULL);
        chk("done_wr_end",  bus.ur_wr_end, 1);

        // RX ignored once done
        send_frame(8'h55, 1'b1, -1, -1);
        chk("after_done_no_wr", f_wr,          0);
        chk("after_done_end",   bus.ur_wr_end, 1);
        chk("after_done_addr",  bus.address,   FULL);

        // One-clock disable clears done and counter
        @(negedge clk);
        bus.ur_wr_start = 1'b0;
        @(negedge clk);
        chk("clear_wr_end",  bus.ur_wr_end, 0);
        chk("clear_address", bus.address,   0);
        bus.ur_wr_start = 1'b1;
        good_frame("restart_12", 8'h12, 0);

        // Short low glitch while idle
        idle_watch(40, 4);
        chk("glitch_no_wr",   f_wr,        0);
        chk("glitch_no_ferr", f_fe,        0);
        chk("glitch_addr",    bus.address, 1);

        // Bad stop bit
        send_frame(8'h81, 1'b0, -1, -1);
        chk("ferr_cnt",   f_fe,        1);
        chk("ferr_at",    f_fe_at,     WR_AT);
        chk("ferr_no_wr", f_wr,        0);
        chk("ferr_addr",  bus.address, 1);
        good_frame("after_ferr_7e", 8'h7E, 1);

        // Abort during data bit 3 of the second byte of a sequence
        good_frame("pre_abort_11", 8'h11, 2);
        send_frame(8'h22, 1'b1, 70, -1);
        chk("abort_no_wr",  f_wr,          0);
        chk("abort_addr",   bus.address,   0);
        chk("abort_wr_end", bus.ur_wr_end, 0);
        bus.ur_wr_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            good_frame($sformatf("frame2_b%0d", i), pat2[i], i);
            chk($sformatf("frame2_b%0d_end_at", i), f_end_at, (i == 3) ? WR_AT + 1 : -1);
        end
        chk("frame2_address", bus.address,   FULL);
        chk("frame2_wr_end",  bus.ur_wr_end, 1);

        // Reset during STOP
        @(negedge clk);
        bus.ur_wr_start = 1'b0;
        @(negedge clk);
        bus.ur_wr_start = 1'b1;
        good_frame("pre_rst_9a", 8'h9A, 0);
        send_frame(8'hB7, 1'b1, -1, 148);
        chk("rst_stop_no_wr",   f_wr,          0);
        chk("rst_stop_no_ferr", f_fe,          0);
        chk("rst_stop_address", bus.address,   0);
        chk("rst_stop_wr_data", bus.wr_data,   0);
        chk("rst_stop_wr_en",   bus.wr_en,     0);
        chk("rst_stop_ferr",    bus.frame_err, 0);
        chk("rst_stop_wr_end",  bus.ur_wr_end, 0);
        good_frame("post_rst_3d", 8'h3D, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
